// File: rtl/regfile_pkg.sv
// Shared constants, types and write-decode helper for the 32x32 register file.
// Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        word_t     data;
    } wr_req_t;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // One-hot write select; all-zero when the port is idle.
    function automatic logic [NUM_REGS-1:0] decode_wr(input logic en, input reg_addr_t addr);
        logic [NUM_REGS-1:0] sel;
        sel       = '0;
        sel[addr] = en;
        return sel;
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// Single register with asynchronous active-low clear and load enable.
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/register_file.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// REGFILE_ZERO_REG_EN makes register 0 a constant zero (writes to it are dropped).
module register_file
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      regWrite,
    input  reg_addr_t rs,
    input  reg_addr_t rt,
    input  reg_addr_t rd,
    input  word_t     data,
    output word_t     outA,
    output word_t     outB
);

    wr_req_t                            wr;
    logic [NUM_REGS-1:0]                wr_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs;

    assign wr     = '{en: regWrite, addr: rd, data: data};
    assign wr_sel = decode_wr(wr.en, wr.addr);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_REG && i == 0) begin : g_zero
            logic unused_sel0;
            assign unused_sel0 = wr_sel[i];
            assign regs[i]     = '0;
        end else begin : g_cell
            regfile_cell #(.W(DATA_W)) u_cell (
                .clk   (clk),
                .rst_n (reset),
                .en    (wr_sel[i]),
                .d     (wr.data),
                .q     (regs[i])
            );
        end
    end

    // No write-to-read bypass: reads see the value stored before the edge.
    assign outA = regs[rs];
    assign outB = regs[rt];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, corner sequences, random vs array model.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [4:0]  rs, rt, rd;
    logic [31:0] data;
    logic [31:0] outA, outB;

    int vectors = 0;
    int miscompares = 0;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    register_file dut (
        .clk      (clk),
        .reset    (reset),
        .regWrite (regWrite),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .data     (data),
        .outA     (outA),
        .outB     (outB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl[8];
    logic [31:0] model[32];

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (ZR && a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    initial begin
        bit rst_low;
        logic [31:0] exp0;

        reset = 1'b0; regWrite = 1'b0; rs = '0; rt = '0; rd = '0; data = '0;

        // Table: inputs applied before an edge, outputs checked just after it
        tbl[0] = '{1'b1, 5'd4, 32'h12341235, 5'd6, 5'd1, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 5'd6, 32'h12341235, 5'd6, 5'd1, 32'h12341235, 32'h0};
        tbl[2] = '{1'b1, 5'd1, 32'h12341235, 5'd6, 5'd1, 32'h12341235, 32'h12341235};
        tbl[3] = '{1'b1, 5'd2, 32'h12341235, 5'd6, 5'd1, 32'h12341235, 32'h12341235};
        tbl[4] = '{1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd6, 32'h0,        32'h12341235};
        tbl[5] = '{1'b0, 5'd6, 32'h54345675, 5'd6, 5'd1, 32'h12341235, 32'h12341235};
        tbl[6] = '{1'b1, 5'd31, 32'hA5A5_0F0F, 5'd31, 5'd31, 32'hA5A50F0F, 32'hA5A50F0F};
        tbl[7] = '{1'b0, 5'd4, 32'h0,        5'd4, 5'd2, 32'h12341235, 32'h12341235};

        // Reset held low across an edge: reads are zero, writes blocked
        @(negedge clk);
        regWrite = 1'b1; rd = 5'd9; data = 32'hCAFEF00D; rs = 5'd9; rt = 5'd0;
        @(posedge clk); #1;
        check("reset_blocks_write", outA, 32'h0);
        @(negedge clk);
        regWrite = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #1;
            check("reset_rdA", outA, 32'h0);
            check("reset_rdB", outB, 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            regWrite = tbl[i].we; rd = tbl[i].rd; data = tbl[i].data;
            rs = tbl[i].rs; rt = tbl[i].rt;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_A", i), outA, tbl[i].ea);
            check($sformatf("tbl%0d_B", i), outB, tbl[i].eb);
        end

        // Overwrite: old value until the edge, new value right after
        @(negedge clk);
        regWrite = 1'b1; rd = 5'd6; data = 32'h55558888; rs = 5'd6; rt = 5'd1;
        #1;
        check("ovr_pre_A", outA, 32'h12341235);
        @(posedge clk); #1;
        check("ovr_post_A", outA, 32'h55558888);
        check("ovr_post_B", outB, 32'h12341235);

        // Async reset between edges with a write pending
        @(negedge clk);
        regWrite = 1'b1; rd = 5'd2; data = 32'h77777777; rs = 5'd6; rt = 5'd1;
        #2 reset = 1'b0;
        #1;
        check("arst_A", outA, 32'h0);
        check("arst_B", outB, 32'h0);
        @(posedge clk); #1;
        rs = 5'd2;
        #1;
        check("arst_wr_lost", outA, 32'h0);
        @(negedge clk);
        reset = 1'b1; regWrite = 1'b0;
        #1;
        check("arst_post_rel", outA, 32'h0);

        // Register 0 write
        exp0 = ZR ? 32'h0 : 32'hDEADBEEF;
        @(negedge clk);
        regWrite = 1'b1; rd = 5'd0; data = 32'hDEADBEEF; rs = 5'd0; rt = 5'd0;
        @(posedge clk); #1;
        check("reg0_A", outA, exp0);
        check("reg0_B", outB, exp0);

        // Random: synchronise model with a reset, then compare every cycle
        @(negedge clk);
        regWrite = 1'b0; reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_low  = ($urandom_range(0, 39) == 0);
            reset    = !rst_low;
            regWrite = $urandom_range(0, 2) != 0;
            rd       = 5'($urandom_range(0, 31));
            data     = $urandom;
            rs       = ($urandom_range(0, 7) == 0) ? rd : 5'($urandom_range(0, 31));
            rt       = ($urandom_range(0, 7) == 0) ? rs : 5'($urandom_range(0, 31));
            #1;
            if (rst_low)
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            check("rnd_A", outA, mread(rs));
            check("rnd_B", outB, mread(rt));
            @(posedge clk);
            if (reset && regWrite) model[rd] = data;
            #1;
            check("rnd_post_A", outA, mread(rs));
            check("rnd_post_B", outB, mread(rt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the multi-cycle datapath.
- Two combinational read ports (rs -> outA, rt -> outB) and one synchronous write port (rd, data, regWrite).
- Built from a 1-to-32 write-address decoder, 32 enable-gated register cells, and two 32-to-1 read multiplexers.

Parameters:
- DATA_W, 32, width of each register and of the data/read buses.
- ADDR_W, 5, width of the rs/rt/rd address fields.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register.
- regWrite  input  1  write enable for the write port.
- rs  input  ADDR_W  read address, port A.
- rt  input  ADDR_W  read address, port B.
- rd  input  ADDR_W  write address.
- data  input  DATA_W  write data.
- outA  output  DATA_W  contents of register rs.
- outB  output  DATA_W  contents of register rt.

Behaviour:
- Reset:
  - When reset is driven low, all 32 registers clear to 0x00000000 immediately, independent of clk.
  - While reset is low, writes are blocked and outA/outB read 0.
  - Deassertion is sampled at clk edges; the first write can occur on the first rising edge after reset goes high.
- Write decode: rd is one-hot decoded to 32 lines; register i loads data on a rising clk edge iff regWrite=1, the decoded line i=1, and reset is high. Exactly one register is written per edge.
- regWrite=0: no register changes, whatever the values of rd and data.
- Read: outA = reg[rs] and outB = reg[rt], purely combinational with zero latency. Outputs follow rs/rt changes within the same cycle.
- rs == rt: both outputs carry the same value.
- Read of rd during a write cycle: the old value is returned until the clk edge; the new value appears right after the edge. There is no write-to-read bypass.
- Reset asserted mid-cycle during a pending write: the reset wins and the write is lost.
- Register 0: ordinary read/write storage unless the optional feature is enabled.
- Every address 0-31 is valid; there is no out-of-range case.
- Outputs are never X after reset.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hard-wired to zero, writes to rd=0 are ignored, and any read of address 0 returns 0x00000000 (MIPS $zero semantics).
- Undefined: register 0 is an ordinary writable register, identical to registers 1-31.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32;
  - typedefs word_t (logic [DATA_W-1:0]) and reg_addr_t (logic [ADDR_W-1:0]).
- One natural sub-module, regfile_cell: a DATA_W-wide register with async active-low clear and a load enable. It is instantiated NUM_REGS times; for cell 0 under REGFILE_ZERO_REG_EN it is replaced by a constant.
- The decoder and the read multiplexers are inline logic in register_file, not separate modules.

Test Plan:
- Reset: hold reset low, then release; read rs=0..31, rt=31..0 -> every read returns 0x00000000.
- Sequential writes: regWrite=1; on consecutive edges write 0x12341235 to rd=4, 6, 1, 2. Then regWrite=0, rs=6, rt=1 -> outA=outB=0x12341235, and rs=3 -> 0.
- Write disabled: regWrite=0, rd=6, data=0x54345675, one edge -> outA (rs=6) stays 0x12341235.
- Overwrite and timing: regWrite=1, rd=6, data=0x55558888, rs=6 -> outA stays 0x12341235 until the rising edge, then becomes 0x55558888; outB (rt=1) is unchanged.
- Async reset mid-operation: pull reset low between edges after the writes above -> outA/outB drop to 0 before the next clk edge, and a write attempted while reset is low is not stored.
- Register 0: write 0xDEADBEEF to rd=0, read rs=0 -> 0xDEADBEEF without REGFILE_ZERO_REG_EN, 0x00000000 with it.
